// File: rtl/nibble_serial_tx_if.sv
// Parallel word handshake into the nibble serial transmitter.
interface nibble_serial_tx_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] din;
    logic              valid;
    logic              ready;

    modport master (output din, output valid, input ready);
    modport slave  (input din, input valid, output ready);
endinterface

// File: rtl/nibble_serial_tx.sv
// Serial transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each held CLKS_PER_BIT clocks. All outputs except ready are registered.
module nibble_serial_tx #(
    parameter int DATA_W       = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_tx_if.slave  bus,
    output logic               tx,
    output logic               busy,
    output logic               done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // Only consulted in STOP when CLKS_PER_BIT >= 2, so the wrap at 1 is harmless.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BIT_W-1:0]    r_bit;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic                w_baud_end;
    logic                w_accept;
    logic [DATA_W-1:0]   w_shift_nxt;

    assign w_baud_end  = (r_baud == BAUD_LAST);
    assign w_shift_nxt = r_shift >> 1;
    assign bus.ready   = (r_state == IDLE) && !rst;
    assign w_accept    = bus.valid && bus.ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift <= bus.din;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == BIT_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                            // A one-clock stop bit is also the last stop cycle.
                            r_done  <= (CLKS_PER_BIT == 1);
                        end else begin
                            r_shift <= w_shift_nxt;
                            r_tx    <= w_shift_nxt[0];
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        r_done <= (r_baud == BAUD_PRE);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;
endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx in three configurations:
// A (DATA_W=4, CLKS_PER_BIT=4), B (4, 1) and C (8, 2).
module tb_nibble_serial_tx;
    localparam int LEN_A = 24;
    localparam int LEN_B = 6;
    localparam int LEN_C = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nibble_serial_tx_if #(.DATA_W(4)) bus_a ();
    nibble_serial_tx_if #(.DATA_W(4)) bus_b ();
    nibble_serial_tx_if #(.DATA_W(8)) bus_c ();

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .tx(tx_a), .busy(busy_a), .done(done_a));
    nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .tx(tx_b), .busy(busy_b), .done(done_b));
    nibble_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(2)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    int tests = 0;
    int fails = 0;

    logic [63:0] expq_a[$];
    logic [63:0] expq_b[$];
    logic [63:0] expq_c[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // seq holds the line bits in time order, first bit at position nb-1.
    function automatic logic [63:0] expand(input logic [15:0] seq, input int nb, input int cpb);
        logic [63:0] r;
        r = '0;
        for (int i = nb - 1; i >= 0; i--)
            for (int j = 0; j < cpb; j++)
                r = {r[62:0], seq[i]};
        return r;
    endfunction

    function automatic logic done_sel(input int sel);
        case (sel)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int sel, input int max);
        int n;
        n = 0;
        @(negedge clk);
        while (done_sel(sel) !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("done seen within bound (dut %0d)", sel), 64'(n < max), 64'(1));
    endtask

    // Monitors: collect tx while busy, compare the whole frame when done pulses.
    logic [63:0] cap_a = '0, cap_b = '0, cap_c = '0;
    int          ncyc_a = 0, ncyc_b = 0, ncyc_c = 0;
    logic        rhi_a = 1'b0, rhi_b = 1'b0, rhi_c = 1'b0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (busy_a) begin
            cap_a = {cap_a[62:0], tx_a};
            ncyc_a++;
            if (bus_a.ready) rhi_a = 1'b1;
        end else if (!done_a) begin
            cap_a = '0; ncyc_a = 0; rhi_a = 1'b0;
        end
        if (done_a) begin
            chk("A frame expected at done", 64'(expq_a.size() > 0), 64'(1));
            if (expq_a.size() > 0) begin
                e = expq_a.pop_front();
                chk("A tx pattern", cap_a, e);
                chk("A busy cycles", 64'(ncyc_a), 64'(LEN_A));
                chk("A ready high during frame", 64'(rhi_a), 64'(0));
            end
            cap_a = '0; ncyc_a = 0; rhi_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (busy_b) begin
            cap_b = {cap_b[62:0], tx_b};
            ncyc_b++;
            if (bus_b.ready) rhi_b = 1'b1;
        end else if (!done_b) begin
            cap_b = '0; ncyc_b = 0; rhi_b = 1'b0;
        end
        if (done_b) begin
            chk("B frame expected at done", 64'(expq_b.size() > 0), 64'(1));
            if (expq_b.size() > 0) begin
                e = expq_b.pop_front();
                chk("B tx pattern", cap_b, e);
                chk("B busy cycles", 64'(ncyc_b), 64'(LEN_B));
                chk("B ready high during frame", 64'(rhi_b), 64'(0));
            end
            cap_b = '0; ncyc_b = 0; rhi_b = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (busy_c) begin
            cap_c = {cap_c[62:0], tx_c};
            ncyc_c++;
            if (bus_c.ready) rhi_c = 1'b1;
        end else if (!done_c) begin
            cap_c = '0; ncyc_c = 0; rhi_c = 1'b0;
        end
        if (done_c) begin
            chk("C frame expected at done", 64'(expq_c.size() > 0), 64'(1));
            if (expq_c.size() > 0) begin
                e = expq_c.pop_front();
                chk("C tx pattern", cap_c, e);
                chk("C busy cycles", 64'(ncyc_c), 64'(LEN_C));
                chk("C ready high during frame", 64'(rhi_c), 64'(0));
            end
            cap_c = '0; ncyc_c = 0; rhi_c = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus_a.din = '0; bus_a.valid = 1'b0;
        bus_b.din = '0; bus_b.valid = 1'b0;
        bus_c.din = '0; bus_c.valid = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset tx A", 64'(tx_a), 64'(1));
        chk("reset busy A", 64'(busy_a), 64'(0));
        chk("reset done A", 64'(done_a), 64'(0));
        chk("reset ready A", 64'(bus_a.ready), 64'(0));
        chk("reset tx B", 64'(tx_b), 64'(1));
        chk("reset ready C", 64'(bus_c.ready), 64'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("ready after reset A", 64'(bus_a.ready), 64'(1));
        chk("ready after reset B", 64'(bus_b.ready), 64'(1));
        chk("ready after reset C", 64'(bus_c.ready), 64'(1));

        // Single frame 1011, with ignored requests and din toggling mid-frame
        tick();
        bus_a.din = 4'b1011; bus_a.valid = 1'b1;
        expq_a.push_back(expand(16'b011011, 6, 4));
        tick();
        bus_a.valid = 1'b0;
        repeat (3) tick();
        bus_a.valid = 1'b1;
        bus_a.din = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            tick();
            bus_a.din = ~bus_a.din;
        end
        bus_a.valid = 1'b0;
        wait_done(0, 40);
        repeat (3) tick();
        chk("A idle after single frame busy", 64'(busy_a), 64'(0));
        chk("A idle after single frame tx", 64'(tx_a), 64'(1));

        // Back-to-back 0101 then 1110 with valid held high
        bus_a.din = 4'b0101; bus_a.valid = 1'b1;
        expq_a.push_back(expand(16'b010101, 6, 4));
        expq_a.push_back(expand(16'b001111, 6, 4));
        tick();
        bus_a.din = 4'b1110;
        wait_done(0, 40);
        @(posedge clk);
        @(negedge clk);
        chk("A gap busy", 64'(busy_a), 64'(0));
        chk("A gap tx", 64'(tx_a), 64'(1));
        @(posedge clk);
        #1 bus_a.valid = 1'b0;
        @(negedge clk);
        chk("A second start busy", 64'(busy_a), 64'(1));
        chk("A second start tx", 64'(tx_a), 64'(0));
        wait_done(0, 40);

        // Reset during the second data bit
        tick();
        bus_a.din = 4'b0110; bus_a.valid = 1'b1;
        tick();
        bus_a.valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("A ready low while rst", 64'(bus_a.ready), 64'(0));
        @(negedge clk);
        chk("A abort tx", 64'(tx_a), 64'(1));
        chk("A abort busy", 64'(busy_a), 64'(0));
        chk("A abort done", 64'(done_a), 64'(0));
        chk("A abort ready", 64'(bus_a.ready), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("A ready after abort", 64'(bus_a.ready), 64'(1));
        tick();
        bus_a.din = 4'b1001; bus_a.valid = 1'b1;
        expq_a.push_back(expand(16'b010011, 6, 4));
        tick();
        bus_a.valid = 1'b0;
        wait_done(0, 40);

        // Minimum divider
        tick();
        bus_b.din = 4'b0110; bus_b.valid = 1'b1;
        expq_b.push_back(expand(16'b001101, 6, 1));
        tick();
        bus_b.valid = 1'b0;
        wait_done(1, 20);

        // Eight-bit frame
        tick();
        bus_c.din = 8'hA5; bus_c.valid = 1'b1;
        expq_c.push_back(expand(16'b0101001011, 10, 2));
        tick();
        bus_c.valid = 1'b0;
        wait_done(2, 40);

        repeat (4) tick();
        chk("A frames left unsent", 64'(expq_a.size()), 64'(0));
        chk("B frames left unsent", 64'(expq_b.size()), 64'(0));
        chk("C frames left unsent", 64'(expq_c.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
